// File: rtl/demux_hold_n_pkg.sv
// Shared definitions for the demux_hold_n block: default parameter values
// and the select-debounce FSM state encoding.
package demux_hold_n_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_N         = 2;
  localparam int unsigned DEF_DB_CYCLES = 16;

  // Debounce FSM: IDLE = select in force, SETTLE = candidate being qualified
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } db_state_t;

endpackage

// File: rtl/demux_hold_n_sel_debounce.sv
// Select synchroniser and debouncer for demux_hold_n.
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   sel_raw         raw switch select, asynchronous to clk
//   sel_active      debounced select currently in force (registered)
//   settle_busy_c   next FSM state is SETTLE (combinational)
// A new select takes effect only after it has been seen unchanged for the
// cycle that enters SETTLE plus DB_CYCLES cycles in SETTLE.
module demux_hold_n_sel_debounce
  import demux_hold_n_pkg::*;
#(
  parameter  int unsigned N         = DEF_N,
  parameter  int unsigned DB_CYCLES = DEF_DB_CYCLES,
  localparam int unsigned SELW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel_raw,
  output logic [SELW-1:0] sel_active,
  output logic            settle_busy_c
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SELW-1:0] sync1_q, sync2_q, sel_s;
  logic [SELW-1:0] cand_q, cand_d;
  logic [SELW-1:0] active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  db_state_t       state_q, state_d;

  // Two-flop synchroniser on the raw switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sel_raw;
      sync2_q <= sync1_q;
    end
  end

  // Out-of-range selects map to the last channel; no clamp when N fills SELW
  generate
    if (N == (1 << SELW)) begin : g_noclamp
      assign sel_s = sync2_q;
    end else begin : g_clamp
      localparam logic [SELW-1:0] MAX_SEL = SELW'(N - 1);
      assign sel_s = (sync2_q > MAX_SEL) ? MAX_SEL : sync2_q;
    end
  endgenerate

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_s != active_q) begin
          state_d = ST_SETTLE;
          cand_d  = sel_s;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (sel_s == active_q) begin
          // switch bounced back to the current select
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sel_s != cand_q) begin
          // a different candidate restarts qualification
          cand_d = sel_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          active_d = cand_q;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel_active    = active_q;
  assign settle_busy_c = (state_d == ST_SETTLE);

endmodule

// File: rtl/demux_hold_n.sv
// Registered 1-to-N demultiplexer with held channels and debounced select.
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   sel_raw       raw switch select (SELW bits), asynchronous to clk
//   in_data/in_valid  result word and its valid flag
//   in_ready      block accepts a word this cycle (registered)
//   out_data      N*W bits, channel k at [k*W +: W]
//   out_upd       one-cycle pulse per channel written on the last edge
//   sel_active    debounced select currently in force
// Build option: DEMUX_BLANK_EN shows only the selected channel, others read 0;
// held channel registers are unaffected either way.
module demux_hold_n
  import demux_hold_n_pkg::*;
#(
  parameter  int unsigned W         = DEF_W,
  parameter  int unsigned N         = DEF_N,
  parameter  int unsigned DB_CYCLES = DEF_DB_CYCLES,
  localparam int unsigned SELW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel_raw,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_upd,
  output logic [SELW-1:0] sel_active
);

  logic           settle_busy_c;
  logic           xfer_c;
  logic [N-1:0]   upd_c;
  logic [N*W-1:0] ch_q;

  demux_hold_n_sel_debounce #(
    .N         (N),
    .DB_CYCLES (DB_CYCLES)
  ) u_sel_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_raw       (sel_raw),
    .sel_active    (sel_active),
    .settle_busy_c (settle_busy_c)
  );

  // Ready is low for every cycle the debouncer spends in SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= !settle_busy_c;
    end
  end

  assign xfer_c = in_valid && in_ready;

  // One-hot write enable; uses the select in force before this edge
  always_comb begin
    upd_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (xfer_c && (sel_active == SELW'(k))) begin
        upd_c[k] = 1'b1;
      end
    end
  end

  // Channel registers and update pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      out_upd <= '0;
    end else begin
      out_upd <= upd_c;
      for (int unsigned k = 0; k < N; k++) begin
        if (upd_c[k]) begin
          ch_q[k*W +: W] <= in_data;
        end
      end
    end
  end

`ifdef DEMUX_BLANK_EN
  // Only the selected channel is visible
  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel_active == SELW'(k)) begin
        out_data[k*W +: W] = ch_q[k*W +: W];
      end
    end
  end
`else
  assign out_data = ch_q;
`endif

endmodule
